// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants and types for the host-to-FPGA UART command receiver.
package uart_cmd_rx_pkg;

    // 200 MHz system clock divided by 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 1736;
    localparam int SYNC_STAGES_DEFAULT  = 2;

    // Opcodes understood by the command decoder
    localparam logic [7:0] OPC_WRITE   = 8'h57;  // 'W'
    localparam logic [7:0] OPC_READ    = 8'h52;  // 'R'
    localparam logic [7:0] OPC_DEBUG   = 8'h44;  // 'D'
    localparam logic [7:0] OPC_SOFTRST = 8'h58;  // 'X'
    localparam logic [7:0] OPC_SELECT  = 8'h53;  // 'S', followed by one argument byte

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic {
        CMD_IDLE,
        CMD_ARG
    } cmd_state_t;

    // The selector argument is legal only when its upper six bits are clear
    function automatic logic isSelectArg(input logic [7:0] argByte);
        return (argByte[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Signal bundle between the command receiver and the rest of the readout core.
// The slave side is the receiver itself; the master side drives rx and sys_busy.
interface uart_cmd_rx_if;

    logic       rx;
    logic       sys_busy;
    logic       rts_n;
    logic       cmd_start_write;
    logic       cmd_start_read;
    logic       cmd_debug;
    logic       cmd_soft_rst;
    logic [1:0] selector;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       cmd_err;

    modport slave (
        input  rx,
        input  sys_busy,
        output rts_n,
        output cmd_start_write,
        output cmd_start_read,
        output cmd_debug,
        output cmd_soft_rst,
        output selector,
        output rx_data,
        output rx_valid,
        output frame_err,
        output cmd_err
    );

    modport master (
        output rx,
        output sys_busy,
        input  rts_n,
        input  cmd_start_write,
        input  cmd_start_read,
        input  cmd_debug,
        input  cmd_soft_rst,
        input  selector,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  cmd_err
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizes the asynchronous rx line, finds the start
// bit, samples each bit near its middle and reports good bytes or bad stops.
module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       in_break_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // The start-bit countdown is two short because the falling edge is seen
    // one cycle late (previous-value compare) and the load itself costs one.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] syncChain_q;
    logic                   rxSync;
    logic                   rxPrev_q;

    rx_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bitIdx_q, bitIdx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   stopOk_q, stopOk_d;
    logic                   frameErr_q, frameErr_d;
    logic [7:0]             data_q;
    logic                   valid_q;

    assign rxSync = syncChain_q[SYNC_STAGES-1];

    // Metastability synchronizer plus one extra flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            syncChain_q <= '1;
            rxPrev_q    <= 1'b1;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], rx_i};
            rxPrev_q    <= rxSync;
        end
    end

    // Receiver state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= 3'd0;
            shift_q    <= 8'h00;
            stopOk_q   <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            stopOk_q   <= stopOk_d;
            frameErr_q <= frameErr_d;
        end
    end

    // Next-state logic: start detect, mid-bit sampling, stop check, break wait
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        stopOk_d   = 1'b0;
        frameErr_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (rxPrev_q && !rxSync) begin
                    cnt_d   = HALF_LOAD;
                    state_d = RX_START;
                end
            end

            RX_START: begin
                if (cnt_q == '0) begin
                    if (rxSync) begin
                        state_d = RX_IDLE;
                    end else begin
                        cnt_d    = FULL_LOAD;
                        bitIdx_d = 3'd0;
                        state_d  = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxSync, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bitIdx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rxSync) begin
                        stopOk_d = 1'b1;
                        state_d  = RX_IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            RX_BREAK: begin
                if (rxSync) begin
                    state_d = RX_IDLE;
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Publish a good byte one cycle after its stop bit was accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            valid_q <= stopOk_q;
            if (stopOk_q) begin
                data_q <= shift_q;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frameErr_q;
    assign in_break_o  = (state_q == RX_BREAK);

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: turns UART opcodes into the same control pulses the
// push-buttons produce, keeps the selector register and drives RTS.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    uart_cmd_rx_if.slave bus
);

    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       inBreak;

    cmd_state_t cmdState_q, cmdState_d;
    logic [1:0] selector_q, selector_d;
    logic       startWrite_q, startWrite_d;
    logic       startRead_q, startRead_d;
    logic       debug_q, debug_d;
    logic       softRst_q, softRst_d;
    logic       cmdErr_q, cmdErr_d;
    logic       rtsN_q;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (bus.rx),
        .data_o      (rxData),
        .valid_o     (rxValid),
        .frame_err_o (frameErr),
        .in_break_o  (inBreak)
    );

    // Decoder state, selector and registered command pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cmdState_q   <= CMD_IDLE;
            selector_q   <= 2'b00;
            startWrite_q <= 1'b0;
            startRead_q  <= 1'b0;
            debug_q      <= 1'b0;
            softRst_q    <= 1'b0;
            cmdErr_q     <= 1'b0;
        end else begin
            cmdState_q   <= cmdState_d;
            selector_q   <= selector_d;
            startWrite_q <= startWrite_d;
            startRead_q  <= startRead_d;
            debug_q      <= debug_d;
            softRst_q    <= softRst_d;
            cmdErr_q     <= cmdErr_d;
        end
    end

    // Opcode decode; soft reset is never blocked, everything else is refused while busy
    always_comb begin
        cmdState_d   = cmdState_q;
        selector_d   = selector_q;
        startWrite_d = 1'b0;
        startRead_d  = 1'b0;
        debug_d      = 1'b0;
        softRst_d    = 1'b0;
        cmdErr_d     = 1'b0;

        case (cmdState_q)
            CMD_IDLE: begin
                if (rxValid) begin
                    case (rxData)
                        OPC_WRITE: begin
                            if (bus.sys_busy) cmdErr_d = 1'b1;
                            else              startWrite_d = 1'b1;
                        end
                        OPC_READ: begin
                            if (bus.sys_busy) cmdErr_d = 1'b1;
                            else              startRead_d = 1'b1;
                        end
                        OPC_DEBUG: begin
                            if (bus.sys_busy) cmdErr_d = 1'b1;
                            else              debug_d = 1'b1;
                        end
                        OPC_SOFTRST: begin
                            softRst_d = 1'b1;
                        end
                        OPC_SELECT: begin
                            if (bus.sys_busy) cmdErr_d = 1'b1;
                            else              cmdState_d = CMD_ARG;
                        end
                        default: begin
                            cmdErr_d = 1'b1;
                        end
                    endcase
                end
            end

            CMD_ARG: begin
                // An accepted select still takes its argument even if busy rose meanwhile
                if (rxValid) begin
                    if (isSelectArg(rxData)) begin
                        selector_d = rxData[1:0];
                    end else begin
                        cmdErr_d = 1'b1;
                    end
                    cmdState_d = CMD_IDLE;
                end else if (frameErr) begin
                    cmdState_d = CMD_IDLE;
                end
            end

            default: begin
                cmdState_d = CMD_IDLE;
            end
        endcase
    end

    // Hold the host off while in reset, while the core is busy, or during a line break
    always_ff @(posedge clk) begin
        if (rst) begin
            rtsN_q <= 1'b1;
        end else begin
            rtsN_q <= bus.sys_busy | inBreak;
        end
    end

    assign bus.rts_n           = rtsN_q;
    assign bus.cmd_start_write = startWrite_q;
    assign bus.cmd_start_read  = startRead_q;
    assign bus.cmd_debug       = debug_q;
    assign bus.cmd_soft_rst    = softRst_q;
    assign bus.selector        = selector_q;
    assign bus.rx_data         = rxData;
    assign bus.rx_valid        = rxValid;
    assign bus.frame_err       = frameErr;
    assign bus.cmd_err         = cmdErr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: serial frames are driven on rx, output
// pulses are tallied each cycle and compared against hand-computed counts.
module tb_uart_cmd_rx;

    localparam int CPB = 16;
    localparam int NV  = 21;

    typedef struct {
        logic [7:0] data;
        bit         stopBit;
        bit         busy;
        int         expWrite;
        int         expRead;
        int         expDebug;
        int         expSoft;
        int         expErr;
        int         expFrame;
        int         expValid;
        logic [1:0] expSel;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    uart_cmd_rx_if bus();

    uart_cmd_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int totWrite = 0, totRead = 0, totDebug = 0, totSoft = 0;
    int totErr = 0, totFrame = 0, totValid = 0;
    int bW, bR, bD, bX, bE, bF, bV;
    int validQ[$];
    int startQ[$];

    logic [7:0] lastGood;
    vec_t       vecs[NV];

    // Free-running cycle count used for latency measurement
    always @(posedge clk) cycle <= cycle + 1;

    // Tally every output pulse away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_start_write) totWrite++;
            if (bus.cmd_start_read)  totRead++;
            if (bus.cmd_debug)       totDebug++;
            if (bus.cmd_soft_rst)    totSoft++;
            if (bus.cmd_err)         totErr++;
            if (bus.frame_err)       totFrame++;
            if (bus.rx_valid) begin
                totValid++;
                validQ.push_back(cycle);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic snapshot();
        bW = totWrite; bR = totRead; bD = totDebug; bX = totSoft;
        bE = totErr;   bF = totFrame; bV = totValid;
    endtask

    task automatic checkDeltas(input string tag, input int w, input int r, input int d,
                               input int x, input int e, input int f, input int v);
        checkOutput({tag, ".write"},    totWrite - bW, w);
        checkOutput({tag, ".read"},     totRead  - bR, r);
        checkOutput({tag, ".debug"},    totDebug - bD, d);
        checkOutput({tag, ".softrst"},  totSoft  - bX, x);
        checkOutput({tag, ".cmderr"},   totErr   - bE, e);
        checkOutput({tag, ".frameerr"}, totFrame - bF, f);
        checkOutput({tag, ".rxvalid"},  totValid - bV, v);
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level
    task automatic applyStimulus(input logic [7:0] data, input bit stopBit);
        startQ.push_back(cycle);
        bus.rx = 1'b0;
        waitCycles(CPB);
        for (int b = 0; b < 8; b++) begin
            bus.rx = data[b];
            waitCycles(CPB);
        end
        bus.rx = stopBit;
        waitCycles(CPB);
    endtask

    initial begin
        int vb;
        int sb;
        logic [7:0] abortByte;

        vecs = '{
            '{8'h53, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1, 2'b00},
            '{8'h02, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1, 2'b10},
            '{8'h53, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1, 2'b10},
            '{8'h06, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 1, 2'b10},
            '{8'h44, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0, 1, 2'b10},
            '{8'h41, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 1, 2'b10},
            '{8'h58, 1'b1, 1'b0, 0, 0, 0, 1, 0, 0, 1, 2'b10},
            '{8'h57, 1'b1, 1'b1, 0, 0, 0, 0, 1, 0, 1, 2'b10},
            '{8'h58, 1'b1, 1'b1, 0, 0, 0, 1, 0, 0, 1, 2'b10},
            '{8'h52, 1'b1, 1'b1, 0, 0, 0, 0, 1, 0, 1, 2'b10},
            '{8'h53, 1'b1, 1'b1, 0, 0, 0, 0, 1, 0, 1, 2'b10},
            '{8'h01, 1'b1, 1'b1, 0, 0, 0, 0, 1, 0, 1, 2'b10},
            '{8'h53, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1, 2'b10},
            '{8'h01, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 1, 2'b01},
            '{8'h53, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1, 2'b01},
            '{8'h03, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1, 0, 2'b01},
            '{8'h44, 1'b1, 1'b0, 0, 0, 1, 0, 0, 0, 1, 2'b01},
            '{8'h53, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1, 2'b01},
            '{8'hFF, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0, 1, 2'b01},
            '{8'h53, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1, 2'b01},
            '{8'h03, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 1, 2'b11}
        };

        // Reset state
        rst          = 1'b1;
        bus.rx       = 1'b1;
        bus.sys_busy = 1'b0;
        waitCycles(4);
        checkOutput("reset.rts_n",    bus.rts_n, 1);
        checkOutput("reset.selector", bus.selector, 0);
        checkOutput("reset.rx_data",  bus.rx_data, 0);
        checkOutput("reset.rx_valid", bus.rx_valid, 0);
        checkOutput("reset.cmd_err",  bus.cmd_err, 0);
        rst = 1'b0;
        waitCycles(4);
        checkOutput("idle.rts_n", bus.rts_n, 0);
        lastGood = 8'h00;

        // Back-to-back 'W' then 'R', with start-edge to rx_valid latency
        snapshot();
        vb = validQ.size();
        sb = startQ.size();
        applyStimulus(8'h57, 1'b1);
        applyStimulus(8'h52, 1'b1);
        waitCycles(24);
        lastGood = 8'h52;
        checkDeltas("b2b", 1, 1, 0, 0, 0, 0, 2);
        checkOutput("b2b.latency0", (validQ.size() > vb)     ? validQ[vb]     - startQ[sb]     : -1, 155);
        checkOutput("b2b.latency1", (validQ.size() > vb + 1) ? validQ[vb + 1] - startQ[sb + 1] : -1, 155);
        checkOutput("b2b.rx_data", bus.rx_data, 8'h52);

        // Table of single frames
        for (int i = 0; i < NV; i++) begin
            bus.sys_busy = vecs[i].busy;
            waitCycles(2);
            snapshot();
            applyStimulus(vecs[i].data, vecs[i].stopBit);
            bus.rx = 1'b1;
            waitCycles(24);
            if (vecs[i].stopBit) lastGood = vecs[i].data;
            checkDeltas($sformatf("vec%0d", i), vecs[i].expWrite, vecs[i].expRead,
                        vecs[i].expDebug, vecs[i].expSoft, vecs[i].expErr,
                        vecs[i].expFrame, vecs[i].expValid);
            checkOutput($sformatf("vec%0d.selector", i), bus.selector, vecs[i].expSel);
            checkOutput($sformatf("vec%0d.rx_data", i), bus.rx_data, lastGood);
            checkOutput($sformatf("vec%0d.rts_n", i), bus.rts_n, vecs[i].busy);
        end
        bus.sys_busy = 1'b0;
        waitCycles(4);

        // Bad stop bit followed by a held-low line, then a clean 'D'
        snapshot();
        applyStimulus(8'h44, 1'b0);
        waitCycles(2 * CPB);
        checkDeltas("break", 0, 0, 0, 0, 0, 1, 0);
        checkOutput("break.rts_n_low_line", bus.rts_n, 1);
        bus.rx = 1'b1;
        waitCycles(10);
        checkOutput("break.rts_n_released", bus.rts_n, 0);
        snapshot();
        applyStimulus(8'h44, 1'b1);
        waitCycles(24);
        lastGood = 8'h44;
        checkDeltas("afterbreak", 0, 0, 1, 0, 0, 0, 1);

        // Four-cycle glitch is ignored, then a normal 'D' still decodes
        snapshot();
        bus.rx = 1'b0;
        waitCycles(4);
        bus.rx = 1'b1;
        waitCycles(40);
        checkDeltas("glitch", 0, 0, 0, 0, 0, 0, 0);
        checkOutput("glitch.rts_n", bus.rts_n, 0);
        snapshot();
        applyStimulus(8'h44, 1'b1);
        waitCycles(24);
        checkDeltas("afterglitch", 0, 0, 1, 0, 0, 0, 1);

        // Reset in the middle of data bit 4 of an 'R' frame
        abortByte = 8'h52;
        bus.rx = 1'b0;
        waitCycles(CPB);
        for (int b = 0; b < 4; b++) begin
            bus.rx = abortByte[b];
            waitCycles(CPB);
        end
        bus.rx = abortByte[4];
        waitCycles(CPB / 2);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("midrst.rts_n",       bus.rts_n, 1);
        checkOutput("midrst.selector",    bus.selector, 0);
        checkOutput("midrst.rx_data",     bus.rx_data, 0);
        checkOutput("midrst.rx_valid",    bus.rx_valid, 0);
        checkOutput("midrst.frame_err",   bus.frame_err, 0);
        checkOutput("midrst.cmd_err",     bus.cmd_err, 0);
        checkOutput("midrst.start_write", bus.cmd_start_write, 0);
        checkOutput("midrst.start_read",  bus.cmd_start_read, 0);
        checkOutput("midrst.debug",       bus.cmd_debug, 0);
        checkOutput("midrst.soft_rst",    bus.cmd_soft_rst, 0);
        bus.rx = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(2 * CPB);
        checkOutput("postrst.rts_n", bus.rts_n, 0);
        snapshot();
        applyStimulus(8'h52, 1'b1);
        waitCycles(24);
        checkDeltas("postrst", 0, 1, 0, 0, 0, 0, 1);
        checkOutput("postrst.rx_data",  bus.rx_data, 8'h52);
        checkOutput("postrst.selector", bus.selector, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
